// File: rtl/fft_stream_n.sv
// Streaming N-point radix-2 DIT FFT/IFFT: bit-reversed load, in-place
// butterflies (one per cycle), then natural-order unload with backpressure.
module fft_stream_n #(
    parameter int N_LOG2 = 3,
    parameter int DW     = 16,
    parameter int FRAC   = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_re,
    input  logic signed [DW-1:0] in_im,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_re,
    output logic signed [DW-1:0] out_im,
    output logic                 out_last,
    output logic                 busy
);

    localparam int N   = 1 << N_LOG2;
    localparam int SW  = DW + 2;
    localparam int PW  = 2 * DW + 2;
    localparam int STW = $clog2(N_LOG2);

    localparam logic signed [SW-1:0] SAT_HI = {3'b000, {(DW-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_LO = {3'b111, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;

    state_t state_q, state_d;

    logic [N_LOG2-1:0] wr_cnt;
    logic [STW-1:0]    stage;
    logic [N_LOG2-2:0] bfly;
    logic [N_LOG2:0]   rd_addr;
    logic              mode_q;

    logic signed [DW-1:0] mem_re [N];
    logic signed [DW-1:0] mem_im [N];

    function automatic logic signed [DW-1:0] tw_val(input int k, input bit use_sin);
        real ang;
        real v;
        int  r;
        ang = 2.0 * 3.14159265358979323846 * real'(k) / real'(N);
        v   = (use_sin ? $sin(ang) : $cos(ang)) * real'(1 << FRAC);
        r   = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
        return DW'(r);
    endfunction

    function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] x);
        logic [N_LOG2-1:0] r;
        for (int i = 0; i < N_LOG2; i++) begin
            r[i] = x[N_LOG2-1-i];
        end
        return r;
    endfunction

    // Inverse frames halve every stage so the full transform carries 1/N.
    function automatic logic signed [DW-1:0] scale_sat(input logic signed [SW-1:0] x,
                                                      input logic inv);
        logic signed [SW-1:0] y;
        y = inv ? (x >>> 1) : x;
        if (y > SAT_HI) begin
            return SAT_HI[DW-1:0];
        end else if (y < SAT_LO) begin
            return SAT_LO[DW-1:0];
        end else begin
            return y[DW-1:0];
        end
    endfunction

    logic signed [DW-1:0] tw_cos [N/2];
    logic signed [DW-1:0] tw_sin [N/2];

    for (genvar k = 0; k < N/2; k++) begin : g_tw
        localparam logic signed [DW-1:0] C_VAL = tw_val(k, 1'b0);
        localparam logic signed [DW-1:0] S_VAL = tw_val(k, 1'b1);
        assign tw_cos[k] = C_VAL;
        assign tw_sin[k] = S_VAL;
    end

    logic              accept_in;
    logic              accept_out;
    logic              last_bfly;
    logic              load_out;

    assign in_ready   = (state_q == LOAD);
    assign busy       = (state_q != LOAD);
    assign accept_in  = in_valid && in_ready;
    assign accept_out = out_valid && out_ready;
    assign last_bfly  = (stage == STW'(N_LOG2 - 1)) && (&bfly);
    assign load_out   = (state_q == UNLOAD) && !rd_addr[N_LOG2] && (!out_valid || out_ready);

    // Butterfly addressing: the stage's span splits the counter into group and position.
    logic [N_LOG2-2:0] low_mask;
    logic [N_LOG2-2:0] pos;
    logic [N_LOG2-2:0] grp;
    logic [N_LOG2-2:0] tw_k;
    logic [N_LOG2-1:0] half_bit;
    logic [N_LOG2-1:0] idx_a;
    logic [N_LOG2-1:0] idx_b;

    always_comb begin
        low_mask = ~({(N_LOG2-1){1'b1}} << stage);
        pos      = bfly & low_mask;
        grp      = bfly & ~low_mask;
        half_bit = {{(N_LOG2-1){1'b0}}, 1'b1} << stage;
        idx_a    = {grp, 1'b0} | {1'b0, pos};
        idx_b    = idx_a | half_bit;
        tw_k     = pos << (STW'(N_LOG2 - 1) - stage);
    end

    logic signed [DW-1:0] a_re, a_im, b_re, b_im, w_re, w_im;
    logic signed [PW-1:0] p_re, p_im;
    logic signed [SW-1:0] wb_re, wb_im, s_re, s_im, d_re, d_im;
    logic signed [DW-1:0] na_re, na_im, nb_re, nb_im;

    always_comb begin
        a_re  = mem_re[idx_a];
        a_im  = mem_im[idx_a];
        b_re  = mem_re[idx_b];
        b_im  = mem_im[idx_b];
        w_re  = tw_cos[tw_k];
        w_im  = mode_q ? tw_sin[tw_k] : -tw_sin[tw_k];
        p_re  = PW'(w_re) * PW'(b_re) - PW'(w_im) * PW'(b_im);
        p_im  = PW'(w_re) * PW'(b_im) + PW'(w_im) * PW'(b_re);
        wb_re = SW'(p_re >>> FRAC);
        wb_im = SW'(p_im >>> FRAC);
        s_re  = SW'(a_re) + wb_re;
        s_im  = SW'(a_im) + wb_im;
        d_re  = SW'(a_re) - wb_re;
        d_im  = SW'(a_im) - wb_im;
        na_re = scale_sat(s_re, mode_q);
        na_im = scale_sat(s_im, mode_q);
        nb_re = scale_sat(d_re, mode_q);
        nb_im = scale_sat(d_im, mode_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (accept_in && (&wr_cnt)) state_d = COMPUTE;
            COMPUTE: if (last_bfly)              state_d = UNLOAD;
            UNLOAD:  if (accept_out && out_last) state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt    <= '0;
            stage     <= '0;
            bfly      <= '0;
            rd_addr   <= '0;
            mode_q    <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
        end else begin
            if (accept_in) begin
                if (wr_cnt == '0) begin
                    mode_q <= mode;
                end
                wr_cnt <= wr_cnt + 1'b1;
            end

            if (state_q == COMPUTE) begin
                bfly <= bfly + 1'b1;
                if (last_bfly) begin
                    stage <= '0;
                end else if (&bfly) begin
                    stage <= stage + 1'b1;
                end
            end

            // Output register refills only when empty or being drained.
            if (load_out) begin
                out_re    <= mem_re[rd_addr[N_LOG2-1:0]];
                out_im    <= mem_im[rd_addr[N_LOG2-1:0]];
                out_last  <= &rd_addr[N_LOG2-1:0];
                out_valid <= 1'b1;
                rd_addr   <= rd_addr + 1'b1;
            end else if (accept_out) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end

            if (accept_out && out_last) begin
                rd_addr <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept_in) begin
            mem_re[bitrev(wr_cnt)] <= in_re;
            mem_im[bitrev(wr_cnt)] <= in_im;
        end else if (state_q == COMPUTE) begin
            mem_re[idx_a] <= na_re;
            mem_im[idx_a] <= na_im;
            mem_re[idx_b] <= nb_re;
            mem_im[idx_b] <= nb_im;
        end
    end

endmodule
